traffic_timer: RTL and testbench
================================

TRAFFIC_TIMER -- requirements
Module: traffic_timer

Interface
REQ-001 SHALL have parameter PRESCALE_DIV, default 100000000, clk cycles per count tick (1 s at 100 MHz); legal range 2..2^27.
REQ-002 SHALL have parameter PS_W, default 27, prescaler counter width; must satisfy 2^PS_W >= PRESCALE_DIV.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-low reset.
REQ-005 SHALL have port timer_en, input, 1, count enable from the controller.
REQ-006 SHALL have port timer_load, input, 1, load request from the controller.
REQ-007 SHALL have port timer_init, input, 4, value to load.
REQ-008 SHALL have port timer_out, output, 4, current count, registered.
REQ-009 SHALL have port timer_zero, output, 1, level, high while timer_out == 0.
REQ-010 SHALL have port timer_done, output, 1, one-cycle pulse on count expiry.

Function
REQ-011 SHALL keep an internal prescaler count ps_cnt[PS_W-1:0] and generate an internal tick when ps_cnt == PRESCALE_DIV-1 with timer_en=1 and timer_load=0.
REQ-012 SHALL increment ps_cnt on each cycle with timer_en=1 and timer_load=0, wrapping to 0 on the tick cycle.
REQ-013 SHALL hold ps_cnt and timer_out unchanged while timer_en=0 and timer_load=0 (pause; resumes from held ps_cnt).
REQ-014 SHALL, when timer_load=1, set timer_out <= timer_init and ps_cnt <= 0 on that edge, regardless of timer_en; load priority over tick/decrement.
REQ-015 SHALL make loaded value visible on timer_out one cycle after the load edge (1-cycle latency); timer_load held high reloads every cycle.
REQ-016 SHALL, on tick with timer_out != 0, set timer_out <= timer_out - 1 (4-bit unsigned).
REQ-017 SHALL saturate at 0: on tick with timer_out == 0, timer_out stays 0; no wrap to 4'hF.
REQ-018 SHALL drive timer_done=1 for exactly the one cycle following the edge where timer_out changes 1 -> 0; otherwise 0.
REQ-019 SHALL NOT pulse timer_done on loading 0, on ticks while already 0, or when a load coincides with a would-be 1 -> 0 tick.
REQ-020 SHALL derive timer_zero combinationally from the timer_out register (no extra latency).
REQ-021 SHALL treat simultaneous timer_en=1, timer_load=1 as a load only; the prescaler does not advance that cycle.

Reset
REQ-022 SHALL, when rst=0 at a rising clk edge, set timer_out=4'h0, ps_cnt=0, timer_done=0; timer_zero consequently 1.
REQ-023 SHALL give reset priority over timer_load and timer_en; reset mid-countdown discards count and prescaler phase.
REQ-024 SHALL require no clk cycles after reset release before accepting a load.

Configuration
REQ-025 SHALL use macro TIMER_PRESCALE_EN: defined -> prescaler per REQ-011..012; undefined -> prescaler removed, every cycle with timer_en=1 and timer_load=0 is a tick, PRESCALE_DIV/PS_W ignored (fast simulation); all other requirements unchanged in both cases.

Verification (PRESCALE_DIV=4, TIMER_PRESCALE_EN defined unless noted)
REQ-026 SHALL cover: rst=0 for 2 cycles with load=1, init=4'h9 -> timer_out=0, timer_zero=1, timer_done=0 throughout.
REQ-027 SHALL cover: load init=4'h3 one cycle, then en=1 -> timer_out 3,2,1,0 changing every 4 cycles; timer_done high exactly 1 cycle after 1->0; timer_out stays 0 afterwards.
REQ-028 SHALL cover: load 4'h5, en=1 for 6 cycles, en=0 for 10 cycles, en=1 -> timer_out=4 frozen during pause, reaches 3 exactly 2 enabled cycles after resume.
REQ-029 SHALL cover: count at 1 with tick due, load=1 init=4'hF same cycle -> timer_out=F next cycle, no timer_done pulse.
REQ-030 SHALL cover: load init=4'h0 with en=1 for 20 cycles -> timer_out=0, timer_zero=1, timer_done never asserted.
REQ-031 SHALL cover: TIMER_PRESCALE_EN undefined, load 4'h2, en=1 -> timer_out 2,1,0 on consecutive cycles, timer_done one cycle after reaching 0.

Source files
------------

// File: rtl/traffic_timer.sv
// Loadable 4-bit down-counter that saturates at zero, paced by a tick from an optional prescaler.
// Build option: define TIMER_PRESCALE_EN to tick once per PRESCALE_DIV enabled cycles; otherwise every enabled cycle ticks.
module traffic_timer #(
    parameter int PRESCALE_DIV = 100000000,
    parameter int PS_W         = 27
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       timer_en,
    input  logic       timer_load,
    input  logic [3:0] timer_init,
    output logic [3:0] timer_out,
    output logic       timer_zero,
    output logic       timer_done
);

    logic [3:0] timer_q, timer_d;
    logic       done_q, done_d;
    logic       tick;

`ifdef TIMER_PRESCALE_EN
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE_DIV - 1);

    logic [PS_W-1:0] ps_cnt_q, ps_cnt_d;

    // A load restarts the prescaler phase so the first decrement is a full period away.
    always_comb begin
        ps_cnt_d = ps_cnt_q;
        tick     = 1'b0;
        if (timer_load) begin
            ps_cnt_d = '0;
        end else if (timer_en) begin
            if (ps_cnt_q == PS_LAST) begin
                tick     = 1'b1;
                ps_cnt_d = '0;
            end else begin
                ps_cnt_d = ps_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ps_cnt_q <= '0;
        end else begin
            ps_cnt_q <= ps_cnt_d;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = (PRESCALE_DIV > 0) && (PS_W > 0);
    assign tick       = timer_en & ~timer_load;
`endif

    always_comb begin
        timer_d = timer_q;
        done_d  = 1'b0;
        if (timer_load) begin
            timer_d = timer_init;
        end else if (tick && (timer_q != 4'd0)) begin
            timer_d = timer_q - 4'd1;
            done_d  = (timer_q == 4'd1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            timer_q <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            timer_q <= timer_d;
            done_q  <= done_d;
        end
    end

    assign timer_out  = timer_q;
    assign timer_zero = (timer_q == 4'd0);
    assign timer_done = done_q;

endmodule

// File: tb/tb_traffic_timer.sv
// Bench for traffic_timer: vector table, hand-built countdown corner cases and random traffic
// compared against an arithmetic reference model of the counter.
module tb_traffic_timer;

`ifdef TIMER_PRESCALE_EN
    localparam int DIV = 4;
`else
    localparam int DIV = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       timer_en = 1'b0;
    logic       timer_load = 1'b0;
    logic [3:0] timer_init = 4'd0;
    logic [3:0] timer_out;
    logic       timer_zero;
    logic       timer_done;

    traffic_timer #(.PRESCALE_DIV(4), .PS_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .timer_en   (timer_en),
        .timer_load (timer_load),
        .timer_init (timer_init),
        .timer_out  (timer_out),
        .timer_zero (timer_zero),
        .timer_done (timer_done)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference state: remaining count, enabled cycles since last load/reset, pending done flag.
    int m_out   = 0;
    int m_phase = 0;
    int m_done  = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       load;
        logic [3:0] init;
        int         exp_out;
        int         exp_zero;
        int         exp_done;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_edge(input logic r, input logic en, input logic ld, input logic [3:0] init);
        if (!r) begin
            m_out = 0; m_phase = 0; m_done = 0;
        end else if (ld) begin
            m_out = int'(init); m_phase = 0; m_done = 0;
        end else if (en) begin
            m_phase++;
            m_done = 0;
            if (m_phase == DIV) begin
                m_phase = 0;
                m_done  = (m_out == 1) ? 1 : 0;
                m_out   = (m_out > 0) ? m_out - 1 : 0;
            end
        end else begin
            m_done = 0;
        end
    endtask

    // Apply one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic drive(input logic r, input logic en, input logic ld, input logic [3:0] init);
        rst = r; timer_en = en; timer_load = ld; timer_init = init;
        @(posedge clk);
        model_edge(r, en, ld, init);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".out"},  int'(timer_out),  m_out);
        chk({tag, ".zero"}, int'(timer_zero), (m_out == 0) ? 1 : 0);
        chk({tag, ".done"}, int'(timer_done), m_done);
    endtask

    initial begin
        int exp_v;
        int held;

        vecs[0] = '{1'b0, 1'b0, 1'b1, 4'h9, 0, 1, 0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 4'h9, 0, 1, 0};
        vecs[2] = '{1'b1, 1'b0, 1'b1, 4'h9, 9, 0, 0};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 4'h7, 7, 0, 0};
        vecs[4] = '{1'b1, 1'b1, 1'b1, 4'h1, 1, 0, 0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 4'h0, 0, 1, 0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 4'hF, 15, 0, 0};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 4'h5, 0, 1, 0};

        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].init);
            chk($sformatf("vec%0d.out", i),  int'(timer_out),  vecs[i].exp_out);
            chk($sformatf("vec%0d.zero", i), int'(timer_zero), vecs[i].exp_zero);
            chk($sformatf("vec%0d.done", i), int'(timer_done), vecs[i].exp_done);
        end

        // Countdown from 3: one decrement per DIV enabled cycles, done right after 1->0.
        drive(1'b1, 1'b0, 1'b1, 4'h3);
        chk("cd.load", int'(timer_out), 3);
        for (int k = 0; k < 4 * DIV + 5; k++) begin
            drive(1'b1, 1'b1, 1'b0, 4'h0);
            exp_v = 3 - (k + 1) / DIV;
            if (exp_v < 0) exp_v = 0;
            chk($sformatf("cd%0d.out", k),  int'(timer_out),  exp_v);
            chk($sformatf("cd%0d.done", k), int'(timer_done), ((k + 1) == 3 * DIV) ? 1 : 0);
            chk_model($sformatf("cd%0d.m", k));
        end

        // Pause holds both count and prescaler phase.
        drive(1'b1, 1'b0, 1'b1, 4'h5);
        for (int k = 0; k < 6; k++) drive(1'b1, 1'b1, 1'b0, 4'h0);
        exp_v = 5 - 6 / DIV; if (exp_v < 0) exp_v = 0;
        chk("pause.pre", int'(timer_out), exp_v);
        held = int'(timer_out);
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 1'b0, 1'b0, 4'h0);
            chk($sformatf("pause%0d.out", k), int'(timer_out), held);
        end
        drive(1'b1, 1'b1, 1'b0, 4'h0);
        drive(1'b1, 1'b1, 1'b0, 4'h0);
        exp_v = 5 - 8 / DIV; if (exp_v < 0) exp_v = 0;
        chk("pause.resume2", int'(timer_out), exp_v);
        chk_model("pause.m");

        // Load colliding with a due 1->0 tick: load wins, no done.
        drive(1'b1, 1'b0, 1'b1, 4'h1);
        for (int k = 0; k < DIV - 1; k++) drive(1'b1, 1'b1, 1'b0, 4'h0);
        chk("coll.pre", int'(timer_out), 1);
        drive(1'b1, 1'b1, 1'b1, 4'hF);
        chk("coll.out",  int'(timer_out),  15);
        chk("coll.done", int'(timer_done), 0);
        drive(1'b1, 1'b0, 1'b0, 4'h0);
        chk("coll.done2", int'(timer_done), 0);

        // Loading zero then counting never pulses done.
        drive(1'b1, 1'b1, 1'b1, 4'h0);
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 1'b1, 1'b0, 4'h0);
            chk($sformatf("zero%0d.out", k),  int'(timer_out),  0);
            chk($sformatf("zero%0d.zero", k), int'(timer_zero), 1);
            chk($sformatf("zero%0d.done", k), int'(timer_done), 0);
        end

        // Reset mid-countdown discards everything.
        drive(1'b1, 1'b0, 1'b1, 4'h8);
        drive(1'b1, 1'b1, 1'b0, 4'h0);
        drive(1'b0, 1'b1, 1'b0, 4'h0);
        chk("rstmid.out",  int'(timer_out),  0);
        chk("rstmid.zero", int'(timer_zero), 1);
        chk_model("rstmid.m");

        // Random traffic against the reference model.
        for (int k = 0; k < 400; k++) begin
            logic r, e, l;
            logic [3:0] v;
            r = ($urandom_range(0, 49) != 0);
            e = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 11) == 0);
            v = 4'($urandom_range(0, 15));
            drive(r, e, l, v);
            chk_model($sformatf("rnd%0d", k));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
